// File: rtl/rv_defs_pkg.sv
// Op-code encodings shared between the decode and execute stages, plus the
// execute-stage ALU result bundle.
package rv_defs_pkg;

  localparam logic [6:0] OH_LUI   = 7'd1;
  localparam logic [6:0] OH_JAL   = 7'd3;
  localparam logic [6:0] OH_BEQ   = 7'd5;
  localparam logic [6:0] OH_BNE   = 7'd6;
  localparam logic [6:0] OH_BLT   = 7'd7;
  localparam logic [6:0] OH_ADDI  = 7'd19;
  localparam logic [6:0] OH_SLTI  = 7'd20;
  localparam logic [6:0] OH_SLTIU = 7'd21;
  localparam logic [6:0] OH_SLLI  = 7'd25;
  localparam logic [6:0] OH_SRLI  = 7'd26;
  localparam logic [6:0] OH_SRAI  = 7'd27;
  localparam logic [6:0] OH_ADD   = 7'd28;
  localparam logic [6:0] OH_SUB   = 7'd29;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] target;
    logic        take;
    logic        known;
  } alu_res_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational execute datapath: ALU result, branch/jump target, taken flag
// and whether the op code is one this stage understands.
module ex_alu
  import rv_defs_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] ins,
  input  logic [31:0] ins_addr,
  input  logic [6:0]  oh,
  output alu_res_t    res
);

  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic [4:0]  sra_idx;
  logic        sra_sign;

  assign b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // id hands SRAI over as a logical shift plus a mask of the vacated bits;
  // the original sign bit now sits at position 31-shamt.
  assign sra_idx  = 5'd31 - ins[24:20];
  assign sra_sign = op1[sra_idx];

  always_comb begin
    res.result = 32'd0;
    res.target = ins_addr + b_imm;
    res.take   = 1'b0;
    res.known  = 1'b1;
    case (oh)
      OH_ADDI, OH_ADD: res.result = op1 + op2;
      OH_SUB:          res.result = op1 - op2;
      OH_SLTI:         res.result = ($signed(op1) < $signed(op2)) ? 32'd1 : 32'd0;
      OH_SLTIU:        res.result = (op1 < op2) ? 32'd1 : 32'd0;
      OH_SLLI:         res.result = op1 << op2[4:0];
      OH_SRLI:         res.result = op1 >> op2[4:0];
      OH_SRAI:         res.result = op1 | (~op2 & {32{sra_sign}});
      OH_LUI:          res.result = {ins[31:12], 12'b0};
      OH_JAL: begin
        res.result = ins_addr + 32'd4;
        res.target = ins_addr + j_imm;
        res.take   = 1'b1;
      end
      OH_BEQ:          res.take = (op1 == op2);
      OH_BNE:          res.take = (op1 != op2);
      OH_BLT:          res.take = ($signed(op1) < $signed(op2));
      default:         res.known = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: registers the ALU writeback, issues fetch redirects and
// holds the squash window and retired-instruction counter.
module ex_stage
  import rv_defs_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [31:0]      op1_i,
  input  logic [31:0]      op2_i,
  input  logic [31:0]      ins_i,
  input  logic [31:0]      ins_addr_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             rd_wen_i,
  input  logic [6:0]       oh_i,
  output logic [4:0]       wb_addr_o,
  output logic [31:0]      wb_data_o,
  output logic             wb_en_o,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             flush_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  alu_res_t   res;
  logic [2:0] flush_cnt;
  logic       accept;

  ex_alu u_alu (
    .op1      (op1_i),
    .op2      (op2_i),
    .ins      (ins_i),
    .ins_addr (ins_addr_i),
    .oh       (oh_i),
    .res      (res)
  );

  assign flush_o = (flush_cnt != 3'd0);
  assign accept  = valid_i & ~flush_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_addr_o   <= 5'd0;
      wb_data_o   <= 32'd0;
      wb_en_o     <= 1'b0;
      jump_en_o   <= 1'b0;
      jump_addr_o <= 32'd0;
      illegal_o   <= 1'b0;
      retired_o   <= '0;
      flush_cnt   <= 3'd0;
    end else begin
      wb_en_o   <= 1'b0;
      jump_en_o <= 1'b0;
      if (flush_cnt != 3'd0)
        flush_cnt <= flush_cnt - 3'd1;
      if (accept) begin
        retired_o <= retired_o + CNT_W'(1);
        if (!res.known)
          illegal_o <= 1'b1;
        if (res.known && rd_wen_i && (rd_addr_i != 5'd0)) begin
          wb_en_o   <= 1'b1;
          wb_addr_o <= rd_addr_i;
          wb_data_o <= res.result;
        end
        // a redirect reloads the window; no redirect can land inside one
        if (res.known && res.take) begin
          jump_en_o   <= 1'b1;
          jump_addr_o <= res.target;
          flush_cnt   <= 3'(FLUSH_CYCLES);
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push their expected next-cycle
// outputs into a queue, a monitor pops and compares after every rising edge.
module tb_ex_stage;
  import rv_defs_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_i;
  logic [31:0]   op1_i, op2_i, ins_i, ins_addr_i;
  logic [4:0]    rd_addr_i;
  logic          rd_wen_i;
  logic [6:0]    oh_i;
  logic [4:0]    wb_addr_o;
  logic [31:0]   wb_data_o;
  logic          wb_en_o;
  logic          jump_en_o;
  logic [31:0]   jump_addr_o;
  logic          flush_o;
  logic          illegal_o;
  logic [CW-1:0] retired_o;

  ex_stage #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .ins_i       (ins_i),
    .ins_addr_i  (ins_addr_i),
    .rd_addr_i   (rd_addr_i),
    .rd_wen_i    (rd_wen_i),
    .oh_i        (oh_i),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .wb_en_o     (wb_en_o),
    .jump_en_o   (jump_en_o),
    .jump_addr_o (jump_addr_o),
    .flush_o     (flush_o),
    .illegal_o   (illegal_o),
    .retired_o   (retired_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          wb_en;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic          jump;
    logic [31:0]   jaddr;
    logic          flush;
    logic          illegal;
    logic [CW-1:0] retired;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, "wb_en", 32'(wb_en_o), 32'(e.wb_en));
      if (e.wb_en) begin
        chk(e.name, "wb_addr", 32'(wb_addr_o), 32'(e.wb_addr));
        chk(e.name, "wb_data", wb_data_o, e.wb_data);
      end
      chk(e.name, "jump_en", 32'(jump_en_o), 32'(e.jump));
      if (e.jump)
        chk(e.name, "jump_addr", jump_addr_o, e.jaddr);
      chk(e.name, "flush", 32'(flush_o), 32'(e.flush));
      chk(e.name, "illegal", 32'(illegal_o), 32'(e.illegal));
      chk(e.name, "retired", 32'(retired_o), 32'(e.retired));
    end
  end

  task automatic cyc(input string name, input logic rst, input logic v,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] ins,
                     input logic [31:0] pc, input logic [4:0] rd, input logic wen, input logic [6:0] oh,
                     input logic ewb, input logic [4:0] ewa, input logic [31:0] ewd,
                     input logic ej, input logic [31:0] eja, input logic ef, input logic eil,
                     input logic [CW-1:0] er);
    exp_t e;
    @(negedge clk);
    rst_n = rst; valid_i = v; op1_i = a; op2_i = b; ins_i = ins; ins_addr_i = pc;
    rd_addr_i = rd; rd_wen_i = wen; oh_i = oh;
    e.name = name; e.wb_en = ewb; e.wb_addr = ewa; e.wb_data = ewd; e.jump = ej;
    e.jaddr = eja; e.flush = ef; e.illegal = eil; e.retired = er;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string name, input logic ef, input logic eil, input logic [CW-1:0] er);
    cyc(name, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 7'd0,
        1'b0, 5'd0, 32'd0, 1'b0, 32'd0, ef, eil, er);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // BEQ/BNE/BLT with imm=+16; JAL with imm=-8
  localparam logic [31:0] INS_B16 = 32'h0000_0800;
  localparam logic [31:0] INS_JM8 = 32'hFF9F_F000;

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; op1_i = '0; op2_i = '0; ins_i = '0; ins_addr_i = '0;
    rd_addr_i = '0; rd_wen_i = 1'b0; oh_i = '0;

    cyc("reset0", 0, 1, 1, 1, 0, 0, 5'd3, 1, OH_ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("reset1", 0, 0, 0, 0, 0, 0, 5'd0, 0, 7'd0,   0, 0, 0, 0, 0, 0, 0, 0);

    cyc("add",   1, 1, 5, 7, 0, 0, 5'd3, 1, OH_ADD, 1, 5'd3, 32'd12, 0, 0, 0, 0, 1);
    cyc("srai",  1, 1, 32'h0F00_0000, 32'h0FFF_FFFF, 32'h0040_0000, 0, 5'd5, 1, OH_SRAI,
        1, 5'd5, 32'hFF00_0000, 0, 0, 0, 0, 2);
    cyc("beq",   1, 1, 9, 9, INS_B16, 32'h100, 5'd0, 0, OH_BEQ, 0, 0, 0, 1, 32'h110, 1, 0, 3);
    cyc("fl1",   1, 1, 1, 1, 0, 0, 5'd4, 1, OH_ADDI, 0, 0, 0, 0, 0, 1, 0, 3);
    cyc("fl2",   1, 1, 1, 1, 0, 0, 5'd4, 1, OH_ADDI, 0, 0, 0, 0, 0, 0, 0, 3);
    cyc("post",  1, 1, 1, 2, 0, 0, 5'd4, 1, OH_ADDI, 1, 5'd4, 32'd3, 0, 0, 0, 0, 4);
    cyc("jal",   1, 1, 0, 0, INS_JM8, 32'h20, 5'd1, 1, OH_JAL, 1, 5'd1, 32'h24, 1, 32'h18, 1, 0, 5);
    idle("jfl1", 1, 0, 5);
    idle("jfl2", 0, 0, 5);
    cyc("x0",    1, 1, 4, 4, 0, 0, 5'd0, 1, OH_ADDI, 0, 0, 0, 0, 0, 0, 0, 6);
    cyc("slti",  1, 1, 32'hFFFF_FFFF, 1, 0, 0, 5'd2, 1, OH_SLTI, 1, 5'd2, 32'd1, 0, 0, 0, 0, 7);
    cyc("sltiu", 1, 1, 32'hFFFF_FFFF, 1, 0, 0, 5'd2, 1, OH_SLTIU, 1, 5'd2, 32'd0, 0, 0, 0, 0, 8);
    cyc("bne_nt",1, 1, 3, 3, INS_B16, 32'h40, 5'd0, 0, OH_BNE, 0, 0, 0, 0, 0, 0, 0, 9);
    cyc("blt",   1, 1, 32'hFFFF_FFFF, 0, INS_B16, 32'h40, 5'd0, 0, OH_BLT, 0, 0, 0, 1, 32'h50, 1, 0, 10);
    idle("bfl1", 1, 0, 10);
    idle("bfl2", 0, 0, 10);
    cyc("illeg", 1, 1, 1, 1, 0, 0, 5'd6, 1, 7'd0, 0, 0, 0, 0, 0, 0, 1, 11);
    cyc("lui",   1, 1, 0, 0, 32'h1234_5000, 0, 5'd7, 1, OH_LUI, 1, 5'd7, 32'h1234_5000, 0, 0, 0, 1, 12);
    cyc("sub",   1, 1, 3, 5, 0, 0, 5'd8, 1, OH_SUB, 1, 5'd8, 32'hFFFF_FFFE, 0, 0, 0, 1, 13);
    cyc("slli",  1, 1, 1, 32'h21, 0, 0, 5'd9, 1, OH_SLLI, 1, 5'd9, 32'd2, 0, 0, 0, 1, 14);
    cyc("srli",  1, 1, 32'h8000_0000, 31, 0, 0, 5'd9, 1, OH_SRLI, 1, 5'd9, 32'd1, 0, 0, 0, 1, 15);
    cyc("wrap",  1, 1, 0, 0, 0, 0, 5'd10, 1, OH_ADD, 1, 5'd10, 32'd0, 0, 0, 0, 1, 0);
    cyc("beq2",  1, 1, 2, 2, INS_B16, 32'h100, 5'd0, 0, OH_BEQ, 0, 0, 0, 1, 32'h110, 1, 1, 1);
    cyc("rstfl", 0, 1, 5, 7, 0, 0, 5'd3, 1, OH_ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("after", 0, 0, 0);
    cyc("add2",  1, 1, 5, 7, 0, 0, 5'd3, 1, OH_ADD, 1, 5'd3, 32'd12, 0, 0, 0, 0, 1);

    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
